// File: rtl/tick_prescaler_if.sv
// Control/status bundle for tick_prescaler: run control in, tick/status out.
interface tick_prescaler_if #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] burst_len;
    logic               tick;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] tick_count;

    modport master (
        output start, stop, div, burst_len,
        input  tick, busy, done, tick_count
    );

    modport slave (
        input  start, stop, div, burst_len,
        output tick, busy, done, tick_count
    );
endinterface

// File: rtl/tick_prescaler.sv
// Programmable tick generator: one-cycle enable every div+1 cycles, optionally
// stopping after a fixed number of ticks with a done pulse.
module tick_prescaler #(
    parameter int DIV_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    tick_prescaler_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BURST_W-1:0] len_q, len_d;
    logic [BURST_W-1:0] tick_count_q, tick_count_d;
    logic               done_q, done_d;
    logic               tick_w;
    logic               last_tick_w;

    assign tick_w      = (state_q == RUN) && (div_cnt_q == div_q);
    assign last_tick_w = tick_w && (len_q != '0) && (tick_count_q == len_q - BURST_W'(1));

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        div_d        = div_q;
        len_d        = len_q;
        tick_count_d = tick_count_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    div_d        = bus.div;
                    len_d        = bus.burst_len;
                    div_cnt_d    = '0;
                    tick_count_d = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                div_cnt_d = tick_w ? '0 : div_cnt_q + DIV_W'(1);
                if (tick_w) begin
                    tick_count_d = tick_count_q + BURST_W'(1);
                end
                // Normal completion takes precedence over a coincident stop.
                if (last_tick_w) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (bus.stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            div_q        <= '0;
            len_q        <= '0;
            tick_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            div_q        <= div_d;
            len_q        <= len_d;
            tick_count_q <= tick_count_d;
            done_q       <= done_d;
        end
    end

    assign bus.tick       = tick_w;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
    assign bus.tick_count = tick_count_q;
endmodule

// File: tb/tb_tick_prescaler.sv
// Self-checking bench for tick_prescaler: scenario table with a per-cycle
// expectation queue, plus hand-written reset/simultaneous-input sequences.
module tb_tick_prescaler;
    localparam int DIV_W   = 16;
    localparam int BURST_W = 8;

    logic clk;
    logic reset;

    tick_prescaler_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

    tick_prescaler #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    div;
        int    len;
        int    stop_c;   // cycle in which stop is driven high, -1 = never
        int    rst_c;    // cycle in which reset is driven low, -1 = never
        int    ign_c;    // cycle with an extra start and new div/len, -1 = never
        int    ncyc;
    } scen_t;

    typedef struct {
        int         cyc;
        logic       tick;
        logic       busy;
        logic       done;
        logic       chk_cnt;
        logic [7:0] cnt;
    } exp_t;

    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    task automatic cmp(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Expected outputs derived from the timing rules: ticks at multiples of
    // div+1 starting at cycle div+1, run ending at burst end, stop or reset.
    function automatic exp_t exp_at(input scen_t s, input int c);
        exp_t e;
        int p, fin, n, lim;
        bit aborted;
        p       = s.div + 1;
        fin     = 1 << 30;
        aborted = 0;
        if (s.len != 0) fin = s.len * p + 1;
        if (s.stop_c >= 1 && s.stop_c + 1 < fin) fin = s.stop_c + 1;
        if (s.rst_c >= 0 && s.rst_c + 1 <= fin) begin
            fin     = s.rst_c + 1;
            aborted = 1;
        end
        e.cyc     = c;
        e.busy    = (c >= 1) && (c < fin);
        e.tick    = e.busy && (c % p == 0);
        e.done    = !aborted && (s.len != 0) && (fin == s.len * p + 1) && (c == fin);
        e.chk_cnt = (c >= 1);
        if (aborted && c >= fin) begin
            e.cnt = 8'd0;
        end else begin
            lim   = (c < fin) ? c : fin;
            n     = (lim - 1) / p;
            e.cnt = 8'(n);
        end
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_exp(input string name, input exp_t e);
        cmp({name, ".tick"}, e.cyc, 32'(bus.tick), 32'(e.tick));
        cmp({name, ".busy"}, e.cyc, 32'(bus.busy), 32'(e.busy));
        cmp({name, ".done"}, e.cyc, 32'(bus.done), 32'(e.done));
        if (e.chk_cnt) cmp({name, ".tick_count"}, e.cyc, 32'(bus.tick_count), 32'(e.cnt));
    endtask

    task automatic run_scen(input scen_t s);
        exp_t e;
        int   bad0;
        bad0 = n_bad;
        sb_q.push_back(exp_at(s, 0));
        for (int c = 0; c < s.ncyc; c++) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s cycle %0d: scoreboard empty, expected an entry", s.name, c);
            end else begin
                e = sb_q.pop_front();
                check_exp(s.name, e);
            end
            // Outside the start cycle div/burst_len carry junk that must be ignored.
            bus.start     = (c == 0) || (c == s.ign_c);
            bus.stop      = (c == s.stop_c);
            reset         = !(c == s.rst_c);
            bus.div       = (c == 0) ? DIV_W'(s.div) : (c == s.ign_c) ? DIV_W'(9) : DIV_W'($urandom);
            bus.burst_len = (c == 0) ? BURST_W'(s.len) : BURST_W'($urandom);
            if (c + 1 < s.ncyc) sb_q.push_back(exp_at(s, c + 1));
            next_cycle();
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        reset     = 1'b1;
        $display("scenario %-12s div=%0d len=%0d cycles=%0d errors=%0d", s.name, s.div, s.len, s.ncyc, n_bad - bad0);
    endtask

    scen_t tbl[$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl = '{
            '{"continuous", 3, 0, 30, -1, -1, 34},
            '{"burst",      1, 3, -1, -1, -1, 10},
            '{"full_rate",  0, 5, -1, -1, -1, 9},
            '{"stop_mid",   2, 0, 7,  -1, -1, 11},
            '{"reset_mid",  4, 0, -1, 6,  -1, 10},
            '{"restart",    4, 2, -1, -1, -1, 14},
            '{"ign_start",  2, 4, -1, -1, 4,  16},
            '{"stop_last",  1, 3, 6,  -1, -1, 10},
            '{"wrap",       0, 0, 259, -1, -1, 263},
            '{"single",     0, 1, -1, -1, -1, 5}
        };

        reset         = 1'b0;
        bus.start     = 1'b1;
        bus.stop      = 1'b0;
        bus.div       = DIV_W'(3);
        bus.burst_len = BURST_W'(2);
        next_cycle();
        next_cycle();
        cmp("reset.tick",       0, 32'(bus.tick),       32'd0);
        cmp("reset.busy",       0, 32'(bus.busy),       32'd0);
        cmp("reset.done",       0, 32'(bus.done),       32'd0);
        cmp("reset.tick_count", 0, 32'(bus.tick_count), 32'd0);
        reset     = 1'b1;
        bus.start = 1'b0;
        next_cycle();
        $display("sequence reset: outputs idle after reset");

        // start and stop together in IDLE: nothing happens
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        bus.div   = DIV_W'(0);
        next_cycle();
        cmp("startstop.busy",       1, 32'(bus.busy),       32'd0);
        cmp("startstop.tick",       1, 32'(bus.tick),       32'd0);
        bus.stop = 1'b0;
        bus.div  = DIV_W'(1);
        bus.burst_len = BURST_W'(0);
        next_cycle();
        cmp("startstop.tick_count", 2, 32'(bus.tick_count), 32'd0);
        bus.start = 1'b0;
        $display("sequence start+stop in IDLE ignored, then start div=1");

        // reset pulsed low between edges has no effect while running
        cmp("glitch.busy_before", 1, 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        next_cycle();
        cmp("glitch.busy_after", 2, 32'(bus.busy), 32'd1);
        cmp("glitch.tick",       2, 32'(bus.tick), 32'd1);
        bus.stop = 1'b1;
        next_cycle();
        cmp("glitch.stopped",    3, 32'(bus.busy), 32'd0);
        cmp("glitch.tick_count", 3, 32'(bus.tick_count), 32'd1);
        bus.stop = 1'b0;
        next_cycle();
        $display("sequence reset glitch between edges ignored, stop idles");

        foreach (tbl[i]) run_scen(tbl[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tick_prescaler.md
TICK_PRESCALER -- requirements
Module: tick_prescaler

Interface
REQ-001 The block SHALL have parameter DIV_W, default 16, meaning the width of the divide-ratio input and the internal divider counter.
REQ-002 The block SHALL have parameter BURST_W, default 8, meaning the width of the burst-length input and the tick counter.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 The port list SHALL be as follows, one port per line:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous reset, active-low.
- start  input  1  level, sampled each clock; begins a run when in IDLE.
- stop  input  1  level, sampled each clock; aborts a run.
- div  input  DIV_W  divide ratio, latched at start; tick period is div+1 cycles.
- burst_len  input  BURST_W  ticks per run, latched at start; 0 means continuous.
- tick  output  1  one-cycle enable pulse for the downstream binary counter's enable.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a burst completes normally.
- tick_count  output  BURST_W  ticks emitted in the current or most recent run.

Function
REQ-005 The FSM SHALL have two states, IDLE and RUN, encoded in a registered state variable.
REQ-006 In IDLE with start=1 and stop=0, the block SHALL latch div into div_q and burst_len into len_q, clear the divider counter, clear tick_count, and enter RUN at the next edge.
REQ-007 In IDLE with start=1 and stop=1 together, the block SHALL remain in IDLE with no state change.
REQ-008 In RUN, the divider counter SHALL increment by 1 each cycle and reload 0 in the cycle where it equals div_q.
REQ-009 tick SHALL be combinational and equal to (state==RUN) AND (divider==div_q), with no other terms.
REQ-010 The first tick SHALL occur div_q+1 cycles after the cycle in which start was sampled, and subsequent ticks SHALL occur every div_q+1 cycles.
REQ-011 With div=0, tick SHALL be high on every RUN cycle.
REQ-012 tick_count SHALL increment on each cycle where tick=1, and SHALL wrap modulo 2^BURST_W when len_q=0.
REQ-013 When len_q!=0 and tick=1 with tick_count==len_q-1, the block SHALL return to IDLE at the next edge, and done SHALL be 1 for exactly the following cycle.
REQ-014 In RUN with stop=1, the block SHALL enter IDLE at the next edge. A tick in that same cycle SHALL still be output and counted. done SHALL NOT pulse.
REQ-015 If stop=1 coincides with the final burst tick, done SHALL pulse, so that normal completion wins.
REQ-016 start SHALL be ignored while in RUN.
REQ-017 Changes on div and burst_len during RUN SHALL have no effect until the next start.
REQ-018 busy SHALL equal (state==RUN).
REQ-019 tick_count SHALL hold its final value in IDLE until the next accepted start.
REQ-020 All arithmetic SHALL be unsigned, and the divider counter SHALL be DIV_W bits wide.

Reset
REQ-021 With reset=0 at a rising edge, the block SHALL set state=IDLE, divider=0, div_q=0, len_q=0, tick_count=0, and done=0.
REQ-022 Because tick and busy are decoded from state, both SHALL be 0 in the cycle after reset.
REQ-023 Reset SHALL take priority over start, stop, and any in-progress run. Asserting reset mid-run SHALL abort the run with no done pulse.
REQ-024 The block SHALL have no asynchronous behaviour: reset asserted between edges SHALL have no effect until the next rising edge.

Verification
REQ-025 Scenario 1, continuous run: div=3, burst_len=0, start pulsed at cycle 0. Required: ticks at cycles 4, 8, 12, ...; busy=1 from cycle 1; done never asserted.
REQ-026 Scenario 2, burst: div=1, burst_len=3, start at cycle 0. Required: ticks at cycles 2, 4, 6; done=1 at cycle 7 only; busy=0 from cycle 7; tick_count=3.
REQ-027 Scenario 3, full rate: div=0, burst_len=5. Required: tick high on cycles 1–5, done at cycle 6, tick_count=5.
REQ-028 Scenario 4, stop mid-run: div=2, burst_len=0, stop=1 at cycle 7. Required: ticks at 3 and 6 only, IDLE at cycle 8, no done, tick_count=2.
REQ-029 Scenario 5, reset mid-run: div=4, reset=0 at cycle 6 for one cycle. Required: all outputs 0 at cycle 7; a later start restarts with the first tick div+1 cycles after start.
REQ-030 Scenario 6, simultaneous and ignored inputs: start=stop=1 in IDLE keeps busy=0. A start pulse while in RUN with a new div=9 does not alter the tick period.
